// File: rtl/log_entry_reader.sv
// Walks a run of log header slots and streams each entry as a header beat
// followed by its data lines, framing the whole run with out_last/out_padbytes.
module log_entry_reader #(
    parameter int NOC_DATA_W      = 512,
    parameter int NOC_PADBYTES    = NOC_DATA_W / 8,
    parameter int NOC_PADBYTES_W  = $clog2(NOC_PADBYTES),
    parameter int LOG_HDR_DEPTH_W = 8,
    parameter int LOG_DEPTH_W     = 12,
    parameter int LEN_W           = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_val,
    output logic                        start_rdy,
    input  logic [LOG_HDR_DEPTH_W-1:0]  start_hdr_addr,
    input  logic [LOG_HDR_DEPTH_W:0]    start_count,
    output logic                        done,
    output logic                        hdr_rd_req_val,
    input  logic                        hdr_rd_req_rdy,
    output logic [LOG_HDR_DEPTH_W-1:0]  hdr_rd_req_addr,
    input  logic                        hdr_rd_resp_val,
    output logic                        hdr_rd_resp_rdy,
    input  logic [63:0]                 hdr_rd_resp_view,
    input  logic [63:0]                 hdr_rd_resp_op,
    input  logic [LOG_DEPTH_W-1:0]      hdr_rd_resp_data_addr,
    input  logic [LEN_W-1:0]            hdr_rd_resp_len,
    output logic                        data_rd_req_val,
    input  logic                        data_rd_req_rdy,
    output logic [LOG_DEPTH_W-1:0]      data_rd_req_addr,
    input  logic                        data_rd_resp_val,
    output logic                        data_rd_resp_rdy,
    input  logic [NOC_DATA_W-1:0]       data_rd_resp_data,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [NOC_DATA_W-1:0]       out_data,
    output logic                        out_last,
    output logic [NOC_PADBYTES_W-1:0]   out_padbytes
);
    localparam int HDR_W = 128 + LEN_W;

    typedef enum logic [2:0] {
        IDLE, HDR_REQ, HDR_RESP, HDR_OUT, DATA_REQ, DATA_RESP, DONE
    } state_t;

    state_t state, state_next;

    logic [LOG_HDR_DEPTH_W-1:0] slot;
    logic [LOG_HDR_DEPTH_W:0]   count_left;
    logic [63:0]                view_q;
    logic [63:0]                op_q;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           lines_left;
    logic [LOG_DEPTH_W-1:0]     line_addr;

    logic                  last_entry;
    logic                  final_line;
    logic                  entry_done;
    logic [LEN_W:0]        len_round;
    logic [LEN_W-1:0]      resp_lines;
    logic [31:0]           pad_full;
    logic [NOC_DATA_W-1:0] hdr_beat;

    assign last_entry = (count_left == (LOG_HDR_DEPTH_W+1)'(1));
    assign final_line = (lines_left == LEN_W'(1));
    assign len_round  = {1'b0, hdr_rd_resp_len} + (LEN_W+1)'(NOC_PADBYTES - 1);
    assign resp_lines = LEN_W'(len_round / (LEN_W+1)'(NOC_PADBYTES));
    assign pad_full   = (32'(NOC_PADBYTES) - (32'(len_q) % 32'(NOC_PADBYTES)))
                        % 32'(NOC_PADBYTES);

    assign hdr_rd_req_addr  = slot;
    assign data_rd_req_addr = line_addr;

    // An entry finishes on its header beat when it has no payload, else on its last line.
    assign entry_done = (state == HDR_OUT && out_rdy && lines_left == '0) ||
                        (state == DATA_RESP && data_rd_resp_val && out_rdy && final_line);

    always_comb begin
        hdr_beat = '0;
        hdr_beat[NOC_DATA_W-1 -: HDR_W] = {view_q, op_q, len_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        start_rdy        = 1'b0;
        done             = 1'b0;
        hdr_rd_req_val   = 1'b0;
        hdr_rd_resp_rdy  = 1'b0;
        data_rd_req_val  = 1'b0;
        data_rd_resp_rdy = 1'b0;
        out_val          = 1'b0;
        out_data         = '0;
        out_last         = 1'b0;
        out_padbytes     = '0;
        case (state)
            IDLE: begin
                start_rdy = 1'b1;
                if (start_val)
                    state_next = (start_count == '0) ? DONE : HDR_REQ;
            end
            HDR_REQ: begin
                hdr_rd_req_val = 1'b1;
                if (hdr_rd_req_rdy) state_next = HDR_RESP;
            end
            HDR_RESP: begin
                hdr_rd_resp_rdy = 1'b1;
                if (hdr_rd_resp_val) state_next = HDR_OUT;
            end
            HDR_OUT: begin
                out_val  = 1'b1;
                out_data = hdr_beat;
                out_last = last_entry && (lines_left == '0);
                if (out_rdy) begin
                    if (lines_left != '0) state_next = DATA_REQ;
                    else                  state_next = last_entry ? DONE : HDR_REQ;
                end
            end
            DATA_REQ: begin
                data_rd_req_val = 1'b1;
                if (data_rd_req_rdy) state_next = DATA_RESP;
            end
            DATA_RESP: begin
                out_val          = data_rd_resp_val;
                out_data         = data_rd_resp_data;
                data_rd_resp_rdy = out_rdy;
                out_last         = data_rd_resp_val && last_entry && final_line;
                out_padbytes     = out_last ? NOC_PADBYTES_W'(pad_full) : '0;
                if (data_rd_resp_val && out_rdy) begin
                    if (!final_line) state_next = DATA_REQ;
                    else             state_next = last_entry ? DONE : HDR_REQ;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= '0;
            count_left <= '0;
            view_q     <= '0;
            op_q       <= '0;
            len_q      <= '0;
            lines_left <= '0;
            line_addr  <= '0;
        end else begin
            if (state == IDLE && start_val) begin
                slot       <= start_hdr_addr;
                count_left <= start_count;
            end
            if (state == HDR_RESP && hdr_rd_resp_val) begin
                view_q     <= hdr_rd_resp_view;
                op_q       <= hdr_rd_resp_op;
                len_q      <= hdr_rd_resp_len;
                line_addr  <= hdr_rd_resp_data_addr;
                lines_left <= resp_lines;
            end
            if (state == DATA_RESP && data_rd_resp_val && out_rdy) begin
                line_addr  <= line_addr + LOG_DEPTH_W'(1);
                lines_left <= lines_left - LEN_W'(1);
            end
            if (entry_done) begin
                slot       <= slot + LOG_HDR_DEPTH_W'(1);
                count_left <= count_left - (LOG_HDR_DEPTH_W+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_log_entry_reader.sv
// Randomised bench for log_entry_reader: behavioural memories, stalling consumer,
// and a reference model that builds the expected beat stream from the header table.
module tb_log_entry_reader;
    localparam int W   = 512;
    localparam int PB  = W / 8;
    localparam int PBW = $clog2(PB);
    localparam int HW  = 8;
    localparam int DW  = 12;
    localparam int LW  = 16;

    logic clk = 1'b0;
    logic rst;
    logic start_val, start_rdy;
    logic [HW-1:0] start_hdr_addr;
    logic [HW:0]   start_count;
    logic done;
    logic hdr_rd_req_val, hdr_rd_req_rdy;
    logic [HW-1:0] hdr_rd_req_addr;
    logic hdr_rd_resp_val, hdr_rd_resp_rdy;
    logic [63:0] hdr_rd_resp_view, hdr_rd_resp_op;
    logic [DW-1:0] hdr_rd_resp_data_addr;
    logic [LW-1:0] hdr_rd_resp_len;
    logic data_rd_req_val, data_rd_req_rdy;
    logic [DW-1:0] data_rd_req_addr;
    logic data_rd_resp_val, data_rd_resp_rdy;
    logic [W-1:0] data_rd_resp_data;
    logic out_val, out_rdy;
    logic [W-1:0] out_data;
    logic out_last;
    logic [PBW-1:0] out_padbytes;

    log_entry_reader dut (
        .clk(clk), .rst(rst),
        .start_val(start_val), .start_rdy(start_rdy),
        .start_hdr_addr(start_hdr_addr), .start_count(start_count), .done(done),
        .hdr_rd_req_val(hdr_rd_req_val), .hdr_rd_req_rdy(hdr_rd_req_rdy),
        .hdr_rd_req_addr(hdr_rd_req_addr),
        .hdr_rd_resp_val(hdr_rd_resp_val), .hdr_rd_resp_rdy(hdr_rd_resp_rdy),
        .hdr_rd_resp_view(hdr_rd_resp_view), .hdr_rd_resp_op(hdr_rd_resp_op),
        .hdr_rd_resp_data_addr(hdr_rd_resp_data_addr), .hdr_rd_resp_len(hdr_rd_resp_len),
        .data_rd_req_val(data_rd_req_val), .data_rd_req_rdy(data_rd_req_rdy),
        .data_rd_req_addr(data_rd_req_addr),
        .data_rd_resp_val(data_rd_resp_val), .data_rd_resp_rdy(data_rd_resp_rdy),
        .data_rd_resp_data(data_rd_resp_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
        .out_last(out_last), .out_padbytes(out_padbytes)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit stall  = 1'b0;

    logic [63:0]   hv [256];
    logic [63:0]   ho [256];
    logic [DW-1:0] hd [256];
    logic [LW-1:0] hl [256];

    logic [W-1:0] beat_d  [$];
    logic [PBW:0] beat_lp [$];
    int hreq_a [$];
    int hreq_c [$];
    int dreq_a [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int st_cyc   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] line_data(input logic [DW-1:0] a);
        logic [W-1:0] d;
        for (int k = 0; k < W / 32; k++) d[k*32 +: 32] = {4'(k), 4'h9, a, 12'hA5C};
        return d;
    endfunction

    task automatic set_entry(input int sl, input int len, input int da);
        hv[sl] = {$urandom, $urandom};
        ho[sl] = {$urandom, $urandom};
        hd[sl] = DW'(da);
        hl[sl] = LW'(len);
    endtask

    // Header memory: one outstanding read, optional random request stall and latency.
    initial begin
        bit rf, pf, pend;
        int dly;
        logic [HW-1:0] a, pa;
        hdr_rd_req_rdy = 1'b1; hdr_rd_resp_val = 1'b0; pend = 1'b0; dly = 0; pa = '0;
        hdr_rd_resp_view = '0; hdr_rd_resp_op = '0; hdr_rd_resp_data_addr = '0; hdr_rd_resp_len = '0;
        forever begin
            @(negedge clk);
            rf = !rst && hdr_rd_req_val && hdr_rd_req_rdy;
            pf = hdr_rd_resp_val && hdr_rd_resp_rdy;
            a  = hdr_rd_req_addr;
            if (rf) begin hreq_a.push_back(int'(a)); hreq_c.push_back(cyc); end
            @(posedge clk); #1;
            if (rst) begin
                pend = 1'b0; hdr_rd_resp_val = 1'b0;
            end else begin
                if (pf) hdr_rd_resp_val = 1'b0;
                if (rf) begin pend = 1'b1; pa = a; dly = stall ? int'($urandom_range(0, 2)) : 0; end
                if (pend && !hdr_rd_resp_val) begin
                    if (dly == 0) begin
                        hdr_rd_resp_val = 1'b1;
                        hdr_rd_resp_view = hv[pa]; hdr_rd_resp_op = ho[pa];
                        hdr_rd_resp_data_addr = hd[pa]; hdr_rd_resp_len = hl[pa];
                        pend = 1'b0;
                    end else dly--;
                end
            end
            hdr_rd_req_rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        bit rf, pf, pend;
        int dly;
        logic [DW-1:0] a, pa;
        data_rd_req_rdy = 1'b1; data_rd_resp_val = 1'b0; data_rd_resp_data = '0;
        pend = 1'b0; dly = 0; pa = '0;
        forever begin
            @(negedge clk);
            rf = !rst && data_rd_req_val && data_rd_req_rdy;
            pf = data_rd_resp_val && data_rd_resp_rdy;
            a  = data_rd_req_addr;
            if (rf) dreq_a.push_back(int'(a));
            @(posedge clk); #1;
            if (rst) begin
                pend = 1'b0; data_rd_resp_val = 1'b0;
            end else begin
                if (pf) data_rd_resp_val = 1'b0;
                if (rf) begin pend = 1'b1; pa = a; dly = stall ? int'($urandom_range(0, 2)) : 0; end
                if (pend && !data_rd_resp_val) begin
                    if (dly == 0) begin
                        data_rd_resp_val = 1'b1; data_rd_resp_data = line_data(pa); pend = 1'b0;
                    end else dly--;
                end
            end
            data_rd_req_rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Stream consumer: records accepted beats and checks that stalled beats hold.
    initial begin
        bit hold;
        logic [W-1:0] hdv;
        logic [PBW:0] hlp;
        out_rdy = 1'b1; hold = 1'b0; hdv = '0; hlp = '0;
        forever begin
            @(negedge clk);
            if (rst) hold = 1'b0;
            else begin
                if (hold) begin
                    check("hold_val", W'(out_val), W'(1));
                    check("hold_data", out_data, hdv);
                    check("hold_last_pad", W'({out_last, out_padbytes}), W'(hlp));
                end
                if (out_val && out_rdy) begin
                    beat_d.push_back(out_data);
                    beat_lp.push_back({out_last, out_padbytes});
                end
                hold = out_val && !out_rdy;
                hdv = out_data; hlp = {out_last, out_padbytes};
                if (done) begin done_cnt++; done_cyc = cyc; end
            end
            @(posedge clk); #1;
            out_rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic clear_logs();
        beat_d.delete(); beat_lp.delete(); hreq_a.delete(); hreq_c.delete(); dreq_a.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input int s, input int n);
        @(posedge clk); #1;
        start_hdr_addr = HW'(s); start_count = (HW+1)'(n); start_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_rdy) begin st_cyc = cyc; break; end
        end
        @(posedge clk); #1;
        start_val = 1'b0;
    endtask

    task automatic run(input string tag, input int s, input int n);
        logic [W-1:0] ed [$];
        logic [PBW:0] elp [$];
        int eh [$];
        int eda [$];
        int lat;
        clear_logs();
        lat = 1;
        for (int e = 0; e < n; e++) begin
            int sl = (s + e) % 256;
            int len = int'(hl[sl]);
            int lines = (len + PB - 1) / PB;
            logic [W-1:0] b;
            b = '0;
            b[W-1 -: 144] = {hv[sl], ho[sl], hl[sl]};
            eh.push_back(sl);
            ed.push_back(b);
            elp.push_back({(e == n - 1) && (lines == 0), PBW'(0)});
            for (int j = 0; j < lines; j++) begin
                int a = (int'(hd[sl]) + j) % 4096;
                bit lst = (e == n - 1) && (j == lines - 1);
                eda.push_back(a);
                ed.push_back(line_data(DW'(a)));
                elp.push_back({lst, lst ? PBW'((PB - len % PB) % PB) : PBW'(0)});
            end
            lat += 3 + 2 * lines;
        end
        do_start(s, n);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, " done_pulses"}, W'(done_cnt), W'(1));
        check({tag, " nbeats"}, W'(beat_d.size()), W'(ed.size()));
        for (int i = 0; i < ed.size() && i < beat_d.size(); i++) begin
            check($sformatf("%s beat%0d data", tag, i), beat_d[i], ed[i]);
            check($sformatf("%s beat%0d last_pad", tag, i), W'(beat_lp[i]), W'(elp[i]));
        end
        check({tag, " nhdr_reqs"}, W'(hreq_a.size()), W'(eh.size()));
        for (int i = 0; i < eh.size() && i < hreq_a.size(); i++)
            check($sformatf("%s hdr_addr%0d", tag, i), W'(hreq_a[i]), W'(eh[i]));
        check({tag, " ndata_reqs"}, W'(dreq_a.size()), W'(eda.size()));
        for (int i = 0; i < eda.size() && i < dreq_a.size(); i++)
            check($sformatf("%s data_addr%0d", tag, i), W'(dreq_a[i]), W'(eda[i]));
        if (!stall) begin
            check({tag, " done_latency"}, W'(done_cyc - st_cyc), W'(lat));
            if (n > 0 && hreq_c.size() > 0)
                check({tag, " first_hdr_latency"}, W'(hreq_c[0] - st_cyc), W'(1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " start_rdy"}, W'(start_rdy), W'(1));
        check({tag, " out_data"}, out_data, '0);
        check({tag, " ctrl_outs"},
              W'({done, hdr_rd_req_val, hdr_rd_req_addr, hdr_rd_resp_rdy, data_rd_req_val,
                  data_rd_req_addr, data_rd_resp_rdy, out_val, out_last, out_padbytes}), '0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start_val = 1'b0; start_hdr_addr = '0; start_count = '0;
        for (int i = 0; i < 256; i++) set_entry(i, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        set_entry(3, 64, 100);
        run("single64", 3, 1);

        set_entry(10, 100, 200);
        set_entry(11, 0, 300);
        run("two_entries", 10, 2);

        set_entry(20, 130, 40);
        run("len130", 20, 1);

        set_entry(255, 128, 4095);
        set_entry(0, 5, 7);
        run("wrap", 255, 2);

        run("count0", 40, 0);

        for (int r = 0; r < 4; r++) begin
            int s = int'($urandom_range(0, 255));
            for (int e = 0; e < 3; e++)
                set_entry((s + e) % 256, int'($urandom_range(0, 300)), int'($urandom_range(0, 4095)));
            stall = 1'b0;
            run($sformatf("rand%0d_nostall", r), s, 3);
            stall = 1'b1;
            run($sformatf("rand%0d_stall", r), s, 3);
            stall = 1'b0;
            repeat (3) @(posedge clk);
        end

        set_entry(50, 640, 1000);
        set_entry(51, 70, 2000);
        clear_logs();
        do_start(50, 1);
        for (int i = 0; i < 200 && beat_d.size() < 3; i++) @(negedge clk);
        for (int i = 0; i < 10 && !out_val; i++) @(negedge clk);
        check("mid_reset reached_data_beat", W'(out_val), W'(1));
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk); @(posedge clk); #2;
        check_reset_outputs("mid_reset_held");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run("after_reset", 51, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
